// File: rtl/aes_key_sched_if.sv
// -----------------------------------------------------------------------------
// aes_key_sched_if
// Handshake and read-port bundle between a key source / round engine (master)
// and the AES-128 key schedule controller (slave).
//   key_in[127:0]      cipher key, [127:96] = w0            (master -> slave)
//   key_valid          key_in valid                         (master -> slave)
//   key_ready          key can be accepted                  (slave -> master)
//   busy               expansion in progress                (slave -> master)
//   done               one-cycle pulse after round key 10   (slave -> master)
//   sched_valid        all 11 round keys valid              (slave -> master)
//   rk_rd_idx[3:0]     round-key read index                 (master -> slave)
//   rk_rd_data[127:0]  round-key read data                  (slave -> master)
//   key_clr            zeroize request, only when AES_KS_ZEROIZE_EN is defined
// -----------------------------------------------------------------------------
interface aes_key_sched_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         sched_valid;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
`ifdef AES_KS_ZEROIZE_EN
    logic         key_clr;

    modport master (
        output key_in, key_valid, rk_rd_idx, key_clr,
        input  key_ready, busy, done, sched_valid, rk_rd_data
    );
    modport slave (
        input  key_in, key_valid, rk_rd_idx, key_clr,
        output key_ready, busy, done, sched_valid, rk_rd_data
    );
`else
    modport master (
        output key_in, key_valid, rk_rd_idx,
        input  key_ready, busy, done, sched_valid, rk_rd_data
    );
    modport slave (
        input  key_in, key_valid, rk_rd_idx,
        output key_ready, busy, done, sched_valid, rk_rd_data
    );
`endif
endinterface

// File: rtl/aes_key_sched.sv
// -----------------------------------------------------------------------------
// aes_key_sched
// Sequential AES-128 key schedule. An accepted cipher key is expanded one
// round per clock (rounds 1..10) and all 11 round keys are buffered for the
// round engine, which reads them through an indexed read port.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-high
//   ks    aes_key_sched_if.slave (key handshake, status, read port)
// Parameter:
//   RD_REG  1 = registered read data (1-cycle latency), 0 = combinational read
// Optional feature macro: AES_KS_ZEROIZE_EN adds ks.key_clr, a one-cycle
// clear of all stored key material that overrides a simultaneous key accept.
// -----------------------------------------------------------------------------
module aes_key_sched #(
    parameter int unsigned RD_REG = 32'd1
) (
    input  logic           clk,
    input  logic           rst,
    aes_key_sched_if.slave ks
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t       state_r, state_n;
    logic [3:0]   rnd_r;
    logic [127:0] cur_key_r;
    logic [127:0] rk_r [0:10];
    logic         done_r, sched_valid_r, key_ready_r, busy_r;
    logic         accept_s, step_s, last_s, clear_s;
    logic [127:0] keyout_s, rd_s, rd_out_s;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254 (0 maps to 0), then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] b;
        sq = a;
        b  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // One key-expansion round: previous round key -> next round key.
    function automatic logic [127:0] key_gen(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w3, rot, t, n0, n1, n2, n3;
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(r), 24'h000000};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign keyout_s = key_gen(cur_key_r, rnd_r);

`ifdef AES_KS_ZEROIZE_EN
    assign clear_s = ks.key_clr;
`else
    assign clear_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_n;
    end

    // Next-state decode and per-edge datapath strobes.
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        last_s   = 1'b0;
        if (clear_s) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE, READY: begin
                    if (ks.key_valid) begin
                        accept_s = 1'b1;
                        state_n  = EXPAND;
                    end else begin
                        state_n  = state_r;
                    end
                end
                EXPAND: begin
                    step_s = 1'b1;
                    if (rnd_r == 4'd10) begin
                        last_s  = 1'b1;
                        state_n = READY;
                    end else begin
                        state_n = EXPAND;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Round counter, working key, round-key file and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_r         <= 4'd0;
            cur_key_r     <= 128'h0;
            done_r        <= 1'b0;
            sched_valid_r <= 1'b0;
            key_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            for (int i = 0; i < 11; i++) rk_r[i] <= 128'h0;
        end else if (clear_s) begin
            rnd_r         <= 4'd0;
            cur_key_r     <= 128'h0;
            done_r        <= 1'b0;
            sched_valid_r <= 1'b0;
            key_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            for (int i = 0; i < 11; i++) rk_r[i] <= 128'h0;
        end else begin
            done_r      <= last_s;
            key_ready_r <= (state_n != EXPAND);
            busy_r      <= (state_n == EXPAND);
            if (accept_s) begin
                rk_r[0]       <= ks.key_in;
                cur_key_r     <= ks.key_in;
                rnd_r         <= 4'd1;
                sched_valid_r <= 1'b0;
            end else if (step_s) begin
                for (int i = 1; i < 11; i++) begin
                    if (rnd_r == i[3:0]) rk_r[i] <= keyout_s;
                end
                cur_key_r <= keyout_s;
                // Counter parks at 10 once the last round key is written.
                if (last_s) begin
                    sched_valid_r <= 1'b1;
                    rnd_r         <= rnd_r;
                end else begin
                    rnd_r         <= rnd_r + 4'd1;
                end
            end else begin
                rnd_r <= rnd_r;
            end
        end
    end

    // Indexed read mux; indices 11..15 fall through to zero.
    always_comb begin
        rd_s = 128'h0;
        for (int i = 0; i < 11; i++) begin
            if (ks.rk_rd_idx == i[3:0]) rd_s = rk_r[i];
            else                        rd_s = rd_s;
        end
    end

    generate
        if (RD_REG != 32'd0) begin : g_rd_reg
            logic [127:0] rd_data_r;
            // Registered read port.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)          rd_data_r <= 128'h0;
                else if (clear_s) rd_data_r <= 128'h0;
                else              rd_data_r <= rd_s;
            end
            assign rd_out_s = rd_data_r;
        end else begin : g_rd_comb
            assign rd_out_s = rd_s;
        end
    endgenerate

    assign ks.rk_rd_data  = rd_out_s;
    assign ks.key_ready   = key_ready_r;
    assign ks.busy        = busy_r;
    assign ks.done        = done_r;
    assign ks.sched_valid = sched_valid_r;

endmodule
